// File: rtl/pram_pkg.sv
// Shared types and helpers for the pram word memory.
// The byte-merge helper feeds both the array write port and the write-first read bypass.
package pram_pkg;

  typedef enum logic {S_INIT, S_RUN} pram_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest DW the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W = 1024;

  typedef struct packed {
    logic vld;
    logic exc;
  } rd_meta_t;

  function automatic logic [MERGE_W-1:0] merge_bytes(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_W/8; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pram_array.sv
// DEPTH x DW storage: byte-enable synchronous write, registered synchronous read.
// One write and one read per cycle; the read returns the pre-edge contents, no reset.
module pram_array
  import pram_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   wa,
  input  logic [DW-1:0]   wd,
  input  logic [DW/8-1:0] wbe,
  input  logic            re,
  input  logic [IW-1:0]   ra,
  output logic [DW-1:0]   rd
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= DW'(merge_bytes(MERGE_W'(mem[wa]), MERGE_W'(wd), (MERGE_W/8)'(wbe)));
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/pram.sv
// Parametrised 1R1W word RAM with byte enables, write-first forwarding and range exceptions.
// Read latency RD_LAT, write ack after 1 cycle; no backpressure, requests ignored only while busy.
module pram
  import pram_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int CLEAR  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            read,
  input  logic [AW-1:0]   r_addr,
  output logic [DW-1:0]   r_line,
  output logic            rrdy,
  output logic            r_exc,
  input  logic            write,
  input  logic [AW-1:0]   w_addr,
  input  logic [DW-1:0]   w_line,
  input  logic [DW/8-1:0] w_be,
  output logic            wrdy,
  output logic            w_exc,
  output logic            busy
);

  localparam int BW  = DW/8;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                       (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST    = IW'(DEPTH-1);

  pram_state_e   state;
  logic [IW-1:0] clr_cnt;

  logic run_acc, sweep_we;
  logic rd_acc, rd_in, rd_hit;
  logic wr_acc, wr_in, wr_hit;
  logic fwd;

  assign run_acc  = rst_n && (state == S_RUN);
  assign sweep_we = rst_n && (state == S_INIT);
  assign rd_in    = {1'b0, r_addr} < DEPTH_W;
  assign wr_in    = {1'b0, w_addr} < DEPTH_W;
  assign rd_acc   = run_acc & read;
  assign wr_acc   = run_acc & write;
  assign rd_hit   = rd_acc & rd_in;
  assign wr_hit   = wr_acc & wr_in;
  assign fwd      = rd_hit & wr_hit & (r_addr == w_addr);

  // The sweep borrows the write port; it never overlaps a user write.
  logic            arr_we;
  logic [IW-1:0]   arr_wa;
  logic [DW-1:0]   arr_wd;
  logic [BW-1:0]   arr_wbe;
  logic [DW-1:0]   arr_rd;

  assign arr_we  = sweep_we | wr_hit;
  assign arr_wa  = sweep_we ? clr_cnt : w_addr[IW-1:0];
  assign arr_wd  = sweep_we ? '0 : w_line;
  assign arr_wbe = sweep_we ? '1 : w_be;

  pram_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .wa  (arr_wa),
    .wd  (arr_wd),
    .wbe (arr_wbe),
    .re  (rd_hit),
    .ra  (r_addr[IW-1:0]),
    .rd  (arr_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= (CLEAR != 0) ? S_INIT : S_RUN;
      clr_cnt <= '0;
      wrdy    <= 1'b0;
      w_exc   <= 1'b0;
    end else begin
      if (state == S_INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST) state <= S_RUN;
      end
      wrdy  <= wr_acc;
      w_exc <= wr_acc & ~wr_in;
    end
  end

  assign busy = (state == S_INIT);

  // Stage 1: array output plus the same-edge write captured for the bypass.
  rd_meta_t      s1;
  logic          s1_fwd;
  logic [DW-1:0] s1_fwd_dat;
  logic [BW-1:0] s1_fwd_be;
  logic [BW-1:0] fwd_be_eff;
  logic [DW-1:0] d1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= '0;
      s1_fwd <= 1'b0;
    end else begin
      s1.vld <= rd_acc;
      s1.exc <= rd_acc & ~rd_in;
      s1_fwd <= fwd;
    end
  end

  always_ff @(posedge clk) begin
    s1_fwd_dat <= w_line;
    s1_fwd_be  <= w_be;
  end

  assign fwd_be_eff = s1_fwd ? s1_fwd_be : '0;

  always_comb begin
    d1 = '0;
    if (s1.vld && !s1.exc)
      d1 = DW'(merge_bytes(MERGE_W'(arr_rd), MERGE_W'(s1_fwd_dat), (MERGE_W/8)'(fwd_be_eff)));
  end

  generate
    if (LAT == RD_LAT_MAX) begin : g_lat2
      // Merged word is frozen here, so later writes cannot disturb it.
      rd_meta_t      s2;
      logic [DW-1:0] s2_dat;

      always_ff @(posedge clk) begin
        if (!rst_n) s2 <= '0;
        else        s2 <= s1;
      end

      always_ff @(posedge clk) begin
        s2_dat <= d1;
      end

      assign rrdy   = s2.vld;
      assign r_exc  = s2.exc;
      assign r_line = s2.vld ? s2_dat : '0;
    end else begin : g_lat1
      assign rrdy   = s1.vld;
      assign r_exc  = s1.exc;
      assign r_line = d1;
    end
  endgenerate

endmodule

// File: tb/tb_pram.sv
// Scoreboard bench for pram: two instances (DEPTH 16/RD_LAT 1 and DEPTH 1024/RD_LAT 2)
// share one random stimulus stream and are checked against a word-array reference model.
module tb_pram;

  logic        clk;
  logic        rst_n;
  logic        read;
  logic [31:0] r_addr;
  logic        write;
  logic [31:0] w_addr;
  logic [31:0] w_line;
  logic [3:0]  w_be;

  logic [31:0] r_line [2];
  logic [1:0]  rrdy, r_exc, wrdy, w_exc, busy;

  pram #(.DW(32), .AW(32), .DEPTH(16), .RD_LAT(1), .CLEAR(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .read(read), .r_addr(r_addr), .r_line(r_line[0]), .rrdy(rrdy[0]), .r_exc(r_exc[0]),
    .write(write), .w_addr(w_addr), .w_line(w_line), .w_be(w_be),
    .wrdy(wrdy[0]), .w_exc(w_exc[0]), .busy(busy[0])
  );

  pram #(.DW(32), .AW(32), .DEPTH(1024), .RD_LAT(2), .CLEAR(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .read(read), .r_addr(r_addr), .r_line(r_line[1]), .rrdy(rrdy[1]), .r_exc(r_exc[1]),
    .write(write), .w_addr(w_addr), .w_line(w_line), .w_be(w_be),
    .wrdy(wrdy[1]), .w_exc(w_exc[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep_of(input int i);
    return (i == 0) ? 16 : 1024;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  typedef struct {
    int          due;
    bit          exc;
    logic [31:0] dat;
  } rexp_t;

  typedef struct {
    int due;
    bit exc;
  } wexp_t;

  rexp_t       rq [2][$];
  wexp_t       wq [2][$];
  logic [31:0] mdl [2][1024];
  int          run_edges [2];
  bit          exp_busy [2];
  bit          rst_seen = 1'b0;
  int          cyc = 0;
  int          nvec = 0;
  int          nfail = 0;

  // Reference model: memory image updated at each accepting edge, writes before reads.
  task automatic model_edge(input int i);
    rexp_t re;
    wexp_t we;
    if (!rst_n) begin
      rq[i].delete();
      wq[i].delete();
      run_edges[i] = 0;
    end else if (run_edges[i] < dep_of(i)) begin
      run_edges[i]++;
      if (run_edges[i] == dep_of(i))
        for (int a = 0; a < 1024; a++) mdl[i][a] = 32'h0;
    end else begin
      if (write) begin
        we.due = cyc;
        we.exc = (w_addr >= 32'(dep_of(i)));
        if (!we.exc)
          for (int b = 0; b < 4; b++)
            if (w_be[b]) mdl[i][w_addr][8*b +: 8] = w_line[8*b +: 8];
        wq[i].push_back(we);
      end
      if (read) begin
        re.due = cyc + lat_of(i) - 1;
        re.exc = (r_addr >= 32'(dep_of(i)));
        re.dat = re.exc ? 32'h0 : mdl[i][r_addr];
        rq[i].push_back(re);
      end
    end
    exp_busy[i] = (run_edges[i] < dep_of(i));
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) rst_seen = 1'b1;
    for (int i = 0; i < 2; i++) model_edge(i);
  end

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic mon(input int i);
    rexp_t re;
    wexp_t we;
    check("busy", i, 32'(busy[i]), 32'(exp_busy[i]));
    if (rrdy[i]) begin
      if (rq[i].size() == 0) begin
        check("unexpected_rrdy", i, 32'(rrdy[i]), 32'h0);
      end else begin
        re = rq[i].pop_front();
        check("rd_latency", i, 32'(cyc), 32'(re.due));
        check("r_exc", i, 32'(r_exc[i]), 32'(re.exc));
        check("r_line", i, r_line[i], re.dat);
      end
    end else begin
      check("r_line_idle", i, r_line[i], 32'h0);
      if (rq[i].size() != 0 && rq[i][0].due <= cyc) begin
        re = rq[i].pop_front();
        check("missing_rrdy", i, 32'(rrdy[i]), 32'h1);
      end
    end
    if (wrdy[i]) begin
      if (wq[i].size() == 0) begin
        check("unexpected_wrdy", i, 32'(wrdy[i]), 32'h0);
      end else begin
        we = wq[i].pop_front();
        check("wr_latency", i, 32'(cyc), 32'(we.due));
        check("w_exc", i, 32'(w_exc[i]), 32'(we.exc));
      end
    end else if (wq[i].size() != 0 && wq[i][0].due <= cyc) begin
      we = wq[i].pop_front();
      check("missing_wrdy", i, 32'(wrdy[i]), 32'h1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_seen)
      for (int i = 0; i < 2; i++) mon(i);
  end

  task automatic drive(input bit rd, input logic [31:0] ra, input bit wr,
                       input logic [31:0] wa, input logic [31:0] wl, input logic [3:0] be);
    read   = rd;
    r_addr = ra;
    write  = wr;
    w_addr = wa;
    w_line = wl;
    w_be   = be;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return $urandom();
    if (s == 1) return 32'(1018 + $urandom_range(0, 10));
    return 32'($urandom_range(0, 20));
  endfunction

  task automatic random_traffic(input int n);
    for (int k = 0; k < n; k++)
      drive($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 2) != 0,
            rnd_addr(), $urandom(), 4'($urandom()));
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reads of addr 5 during and after the short sweep.
    repeat (20) drive(1'b1, 32'd5, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(1020);

    drive(1'b0, 32'h0, 1'b1, 32'd3, 32'hDEADBEEF, 4'hF);
    drive(1'b0, 32'h0, 1'b1, 32'd3, 32'h11223344, 4'b0101);
    drive(1'b1, 32'd3, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(2);

    for (int a = 0; a < 4; a++) drive(1'b0, 32'h0, 1'b1, 32'(a), 32'(16 + a), 4'hF);
    for (int a = 0; a < 4; a++) drive(1'b1, 32'(a), 1'b0, 32'h0, 32'h0, 4'h0);
    idle(3);

    drive(1'b1, 32'd7, 1'b1, 32'd7, 32'hAAAA5555, 4'hF);
    idle(2);

    drive(1'b0, 32'h0, 1'b1, 32'd1023, 32'hCAFEF00D, 4'hF);
    drive(1'b0, 32'h0, 1'b1, 32'd15, 32'h0BADF00D, 4'hF);
    drive(1'b1, 32'd1024, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 32'd16, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 4'hF);
    drive(1'b1, 32'd1023, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 32'd15, 1'b1, 32'd9, 32'h55AA55AA, 4'h0);
    drive(1'b1, 32'd9, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(3);

    random_traffic(3000);

    // Reset lands one cycle after a read is accepted.
    drive(1'b1, 32'd1, 1'b1, 32'd2, 32'h77777777, 4'hF);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1030);
    random_traffic(300);
    idle(6);

    for (int i = 0; i < 2; i++) begin
      check("rq_drained", i, 32'(rq[i].size()), 32'h0);
      check("wq_drained", i, 32'(wq[i].size()), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
